// File: rtl/systolic_seq_ctrl_if.sv
// Operand handshake, skewed array buses and array control bundle for systolic_seq_ctrl.
// The master modport drives jobs and operands; the slave modport is the sequencer.
interface systolic_seq_ctrl_if #(
  parameter int unsigned ROWS      = 32,
  parameter int unsigned COLS      = 32,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned KW        = 16
);
  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*WORD_SIZE-1:0] left_vec;
  logic [COLS*WORD_SIZE-1:0] top_vec;
  logic [ROWS*WORD_SIZE-1:0] left_in_bus;
  logic [COLS*WORD_SIZE-1:0] top_in_bus;
  logic                      ctl_stat_bit;
  logic                      ctl_dummy_fsm_op2_select;
  logic                      ctl_dummy_fsm_out_select;
  logic                      busy;
  logic                      done;

  modport master (
    output start, k_len, in_valid, left_vec, top_vec,
    input  in_ready, left_in_bus, top_in_bus, ctl_stat_bit,
    input  ctl_dummy_fsm_op2_select, ctl_dummy_fsm_out_select, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, left_vec, top_vec,
    output in_ready, left_in_bus, top_in_bus, ctl_stat_bit,
    output ctl_dummy_fsm_op2_select, ctl_dummy_fsm_out_select, busy, done
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a ROWSxCOLS systolic array: feeds operand beats through per-lane skew
// shift registers, then flushes and drains. Define SYSTOLIC_SEQ_STALL_CNT_EN for stall_cnt.
module systolic_seq_ctrl #(
  parameter int unsigned ROWS      = 32,
  parameter int unsigned COLS      = 32,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned KW        = 16
) (
  input logic                clk,
  input logic                rst,
  systolic_seq_ctrl_if.slave bus
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned FlushLen = ROWS + COLS;
  localparam int unsigned DrainLen = ROWS;
  localparam int unsigned CntW     = $clog2(FlushLen + 1);

  typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   beats_q, beats_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            job_start;

  assign job_start    = (state_q == StIdle) && bus.start && (bus.k_len != '0);
  assign bus.in_ready = (state_q == StFeed) && (beats_q != '0);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          beats_d = bus.k_len;
          state_d = StFeed;
        end
      end
      StFeed: begin
        if (accept) begin
          beats_d = beats_q - KW'(1);
          if (beats_q == KW'(1)) begin
            state_d = StFlush;
            cnt_d   = '0;
          end
        end
      end
      StFlush: begin
        if (cnt_q == CntW'(FlushLen - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DrainLen - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy                     = (state_q != StIdle);
  assign bus.done                     = (state_q == StDone);
  assign bus.ctl_dummy_fsm_op2_select = (state_q == StFeed) || (state_q == StFlush);
  assign bus.ctl_stat_bit             = (state_q == StDrain);
  assign bus.ctl_dummy_fsm_out_select = (state_q == StDrain);

  // Lane r is delayed r+1 cycles; anything other than an accepted beat shifts in zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_left
    logic [WORD_SIZE-1:0] sr_q [r+1];
    logic [WORD_SIZE-1:0] lane_in;

    assign lane_in = accept ? bus.left_vec[(r+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) sr_q[j] <= '0;
      end else begin
        sr_q[0] <= lane_in;
        for (int j = 1; j <= r; j++) sr_q[j] <= sr_q[j-1];
      end
    end

    assign bus.left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE] = sr_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    logic [WORD_SIZE-1:0] sr_q [c+1];
    logic [WORD_SIZE-1:0] lane_in;

    assign lane_in = accept ? bus.top_vec[(c+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= c; j++) sr_q[j] <= '0;
      end else begin
        sr_q[0] <= lane_in;
        for (int j = 1; j <= c; j++) sr_q[j] <= sr_q[j-1];
      end
    end

    assign bus.top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE] = sr_q[c];
  end

`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        feed_bubble;

  assign feed_bubble = (state_q == StFeed) && !accept;

  always_ff @(posedge clk) begin
    if (rst || job_start) begin
      stall_q <= '0;
    end else if (feed_bubble && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
